// File: rtl/trace_capture_if.sv
// Capture/read interface of the trace capture unit: the core-side samples in,
// the FIFO read port and status flags out.
interface trace_capture_if #(
  parameter int ADDR_W = 4
);
  logic              enable;
  logic [31:0]       pc;
  logic [31:0]       alu;
  logic [31:0]       mem;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_pc;
  logic [31:0]       rd_alu;
  logic [31:0]       rd_mem;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              halted;
  logic [31:0]       cycle_count;

  modport master (
    output enable, pc, alu, mem, rd_ready,
    input  rd_valid, rd_pc, rd_alu, rd_mem, count, overflow, halted, cycle_count
  );

  modport slave (
    input  enable, pc, alu, mem, rd_ready,
    output rd_valid, rd_pc, rd_alu, rd_mem, count, overflow, halted, cycle_count
  );
endinterface

// File: rtl/trace_capture_unit.sv
// Samples core PC/ALU/MEM into a circular first-word-fall-through buffer and
// stops capturing once the PC repeats HALT_REPEAT times (jump-to-self).
module trace_capture_unit #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HALT_REPEAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  trace_capture_if.slave   tif
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
  } entry_t;

  localparam int              REP_W    = $clog2(HALT_REPEAT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [REP_W-1:0] HALT_AT = REP_W'(HALT_REPEAT);

  state_t            state, state_nxt;
  entry_t            buffer [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              prev_valid;
  logic [31:0]       prev_pc;
  logic [REP_W-1:0]  rep_cnt, rep_nxt;
  logic [31:0]       cycle_count;
  logic              capture, pop, write;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    capture   = tif.enable && (state != HALTED);
    pop       = (count != '0) && tif.rd_ready;
    write     = capture && ((count != FULL_CNT) || pop);
    rep_nxt   = (prev_valid && (tif.pc == prev_pc)) ? rep_cnt + REP_W'(1) : '0;
    state_nxt = state;
    case (state)
      IDLE:    if (tif.enable)  state_nxt = CAPTURE;
      CAPTURE: if (!tif.enable) state_nxt = IDLE;
      default: state_nxt = HALTED;
    endcase
    // The sample that completes the repeat run is still written.
    if (capture && (rep_nxt == HALT_AT)) state_nxt = HALTED;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      prev_valid  <= 1'b0;
      prev_pc     <= '0;
      rep_cnt     <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;
      if (write) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({write, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (capture && !write) overflow <= 1'b1;
      if (capture) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        prev_pc    <= tif.pc;
        prev_valid <= 1'b1;
        rep_cnt    <= rep_nxt;
      end else begin
        prev_valid <= 1'b0;
        rep_cnt    <= '0;
      end
    end
  end

  // NOTE: trace storage is deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (write) buffer[wr_ptr] <= '{pc: tif.pc, alu: tif.alu, mem: tif.mem};
  end

  assign tif.rd_valid    = (count != '0);
  assign tif.rd_pc       = tif.rd_valid ? buffer[rd_ptr].pc  : '0;
  assign tif.rd_alu      = tif.rd_valid ? buffer[rd_ptr].alu : '0;
  assign tif.rd_mem      = tif.rd_valid ? buffer[rd_ptr].mem : '0;
  assign tif.count       = count;
  assign tif.overflow    = overflow;
  assign tif.halted      = (state == HALTED);
  assign tif.cycle_count = cycle_count;

endmodule
